// File: rtl/clk_div_prog.sv
// clk_div_prog: NUM_CH independent programmable clock dividers sharing one
// phase-align strobe. Each channel toggles clk_out[i] every eff=max(act,1)
// clk_in cycles. Divisor updates pass through a shadow register and only
// take effect on a half-period boundary, so no short pulses are produced.
// Optional feature: define CLK_DIV_TICK_EN to get a registered tick pulse
// on every clk_out change; otherwise tick is tied low.
module clk_div_prog #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] half_period,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_q, act_d;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic [CNT_W-1:0] hp;
        logic [CNT_W-1:0] term_val;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             en_q;
        logic             restart;
        logic             terminal;

        assign hp       = half_period[i*CNT_W +: CNT_W];
        // A divisor of zero behaves as one, so the terminal count is 0 as well.
        assign term_val = (act_q == '0) ? '0 : act_q - CNT_W'(1);
        // Sync and the enable rising edge both restart the channel phase.
        assign restart  = sync | (en[i] & ~en_q);
        assign terminal = en[i] & ~restart & (cnt_q == term_val);

        // Next-state for counter, divisors, pending flag and output clock.
        always_comb begin
            cnt_d  = cnt_q;
            act_d  = act_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            clk_d  = clk_q;
            if (restart || terminal) begin
                cnt_d = '0;
                clk_d = restart ? 1'b0 : ~clk_q;
                if (load[i]) begin
                    // New value bypasses the shadow straight into act.
                    shd_d  = hp;
                    act_d  = hp;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                if (en[i]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                end
                if (load[i]) begin
                    shd_d  = hp;
                    pend_d = 1'b1;
                end
            end
        end

        // Channel state registers; reset restores divide-by-2.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                act_q  <= CNT_W'(1);
                shd_q  <= CNT_W'(1);
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                en_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                en_q   <= en[i];
            end
        end

        assign clk_out[i] = clk_q;

`ifdef CLK_DIV_TICK_EN
        logic tick_q;

        // Pulse in exactly the cycle the output clock changes value.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= clk_d ^ clk_q;
            end
        end

        assign tick[i] = tick_q;
`else
        assign tick[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (NUM_CH=2, CNT_W=16): a vector table
// for steady-state division and divisor updates, then hand sequences for
// sync alignment, enable handling and asynchronous reset.
module tb_clk_div_prog;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NVEC   = 33;
`ifdef CLK_DIV_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic                    clk_in = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] half_period;
    logic [NUM_CH-1:0]       load;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;

    clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .half_period (half_period),
        .load        (load),
        .sync        (sync),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  en;
        logic [1:0]  load;
        logic [15:0] hp0;
        logic [15:0] hp1;
        logic [1:0]  exp_clk;
    } vec_t;

    vec_t       vecs [NVEC];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] prev_clk = 2'b00;

    function automatic vec_t mk(input logic [1:0] e, input logic [1:0] l,
                                input logic [15:0] h0, input logic [15:0] h1,
                                input logic [1:0] x);
        vec_t v;
        v.en = e; v.load = l; v.hp0 = h0; v.hp1 = h1; v.exp_clk = x;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [1:0] e, input logic [1:0] l,
                         input logic [15:0] h0, input logic [15:0] h1,
                         input logic s);
        en          = e;
        load        = l;
        half_period = {h1, h0};
        sync        = s;
    endtask

    // Compare clk_out, and tick as the change from the previous expected clk_out.
    task automatic check(input string name, input logic [1:0] exp_clk);
        logic [1:0] exp_tick;
        exp_tick = TICK_ON ? (exp_clk ^ prev_clk) : 2'b00;
        n_checks++;
        if (clk_out !== exp_clk) begin
            n_fail++;
            $display("FAIL %s clk_out: got %b expected %b", name, clk_out, exp_clk);
        end
        n_checks++;
        if (tick !== exp_tick) begin
            n_fail++;
            $display("FAIL %s tick: got %b expected %b", name, tick, exp_tick);
        end
        prev_clk = exp_clk;
    endtask

    task automatic step(input string name, input logic [1:0] e, input logic [1:0] l,
                        input logic [15:0] h0, input logic [15:0] h1,
                        input logic s, input logic [1:0] x);
        drive(e, l, h0, h1, s);
        cyc();
        check(name, x);
    endtask

    initial begin
        // Divide-by-2 start, ch0 -> 5, ch1 -> 0 then 3 (bypass), then 2 (pending).
        vecs[0]  = mk(2'b11, 2'b00, 16'd0, 16'd0, 2'b00);
        vecs[1]  = mk(2'b11, 2'b00, 16'd0, 16'd0, 2'b11);
        vecs[2]  = mk(2'b11, 2'b00, 16'd0, 16'd0, 2'b00);
        vecs[3]  = mk(2'b11, 2'b00, 16'd0, 16'd0, 2'b11);
        vecs[4]  = mk(2'b11, 2'b01, 16'd5, 16'd0, 2'b00);
        vecs[5]  = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b10);
        vecs[6]  = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b00);
        vecs[7]  = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b10);
        vecs[8]  = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b00);
        vecs[9]  = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b11);
        vecs[10] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b01);
        vecs[11] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b11);
        vecs[12] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b01);
        vecs[13] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b11);
        vecs[14] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b00);
        vecs[15] = mk(2'b11, 2'b10, 16'd5, 16'd0, 2'b10);
        vecs[16] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b00);
        vecs[17] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b10);
        vecs[18] = mk(2'b11, 2'b00, 16'd5, 16'd0, 2'b00);
        vecs[19] = mk(2'b11, 2'b10, 16'd5, 16'd3, 2'b11);
        vecs[20] = mk(2'b11, 2'b00, 16'd5, 16'd3, 2'b11);
        vecs[21] = mk(2'b11, 2'b00, 16'd5, 16'd3, 2'b11);
        vecs[22] = mk(2'b11, 2'b00, 16'd5, 16'd3, 2'b01);
        vecs[23] = mk(2'b11, 2'b00, 16'd5, 16'd3, 2'b01);
        vecs[24] = mk(2'b11, 2'b00, 16'd5, 16'd3, 2'b00);
        vecs[25] = mk(2'b11, 2'b00, 16'd5, 16'd3, 2'b10);
        vecs[26] = mk(2'b11, 2'b10, 16'd5, 16'd2, 2'b10);
        vecs[27] = mk(2'b11, 2'b00, 16'd5, 16'd2, 2'b10);
        vecs[28] = mk(2'b11, 2'b00, 16'd5, 16'd2, 2'b00);
        vecs[29] = mk(2'b11, 2'b00, 16'd5, 16'd2, 2'b01);
        vecs[30] = mk(2'b11, 2'b00, 16'd5, 16'd2, 2'b11);
        vecs[31] = mk(2'b11, 2'b00, 16'd5, 16'd2, 2'b11);
        vecs[32] = mk(2'b11, 2'b00, 16'd5, 16'd2, 2'b01);

        // Reset state.
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 16'd0, 16'd0, 1'b0);
        repeat (3) cyc();
        check("reset_state", 2'b00);

        // Release and run the vector table.
        rst_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].load, vecs[i].hp0, vecs[i].hp1, 1'b0);
            cyc();
            check($sformatf("vec%0d", i), vecs[i].exp_clk);
        end

        // Load 4 into both while disabled, start 2 cycles apart, then sync.
        step("dis_clear",  2'b00, 2'b11, 16'd4, 16'd4, 1'b0, 2'b00);
        step("en0_start",  2'b01, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("en0_cnt1",   2'b01, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("en1_start",  2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("skew_a",     2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("skew_b",     2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b01);
        step("sync_edge",  2'b11, 2'b00, 16'd0, 16'd0, 1'b1, 2'b00);
        step("post_sync1", 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("post_sync2", 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("post_sync3", 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("aligned",    2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b11);
        step("en1_fall",   2'b01, 2'b00, 16'd0, 16'd0, 1'b0, 2'b01);

        // Asynchronous reset in the middle of ch0's high phase.
        drive(2'b11, 2'b00, 16'd0, 16'd0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        prev_clk = 2'b00;
        check("async_rst", 2'b00);
        cyc();
        check("rst_hold", 2'b00);
        rst_n = 1'b1;

        // Divide-by-2 restored, then ch0 -> 3.
        step("rr_start", 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("rr_div2a", 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b11);
        step("rr_div2b", 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b00);
        step("rr_div2c", 2'b11, 2'b00, 16'd0, 16'd0, 1'b0, 2'b11);
        step("d3_load",  2'b11, 2'b01, 16'd3, 16'd0, 1'b0, 2'b00);
        step("d3_c1",    2'b11, 2'b00, 16'd3, 16'd0, 1'b0, 2'b10);
        step("d3_c2",    2'b11, 2'b00, 16'd3, 16'd0, 1'b0, 2'b00);
        step("d3_rise",  2'b11, 2'b00, 16'd3, 16'd0, 1'b0, 2'b11);
        step("d3_c4",    2'b11, 2'b00, 16'd3, 16'd0, 1'b0, 2'b01);
        step("d3_c5",    2'b11, 2'b00, 16'd3, 16'd0, 1'b0, 2'b11);
        step("d3_fall",  2'b11, 2'b00, 16'd3, 16'd0, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16: width of each channel's half-period counter and divisor.
REQ-003 SHALL have port clk_in, input, 1: the one clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, NUM_CH: per-channel run enable.
REQ-006 SHALL have port half_period, input, NUM_CH*CNT_W: per-channel divisor; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-007 SHALL have port load, input, NUM_CH: per-channel one-cycle strobe that captures half_period[i] into the channel shadow register.
REQ-008 SHALL have port sync, input, 1: one-cycle strobe that phase-aligns all channels.
REQ-009 SHALL have port clk_out, output, NUM_CH: divided clocks, registered.
REQ-010 SHALL have port tick, output, NUM_CH: one-cycle pulse in the same cycle each clk_out[i] toggles (see Configuration).

Function
REQ-011 Each channel SHALL hold a counter cnt, an active divisor act and a shadow divisor shd, each CNT_W bits wide, plus the output register clk_out[i].
REQ-012 The effective divisor SHALL be eff = (act == 0) ? 1 : act; a divisor of 0 therefore behaves as 1.
REQ-013 Terminal condition: with en[i]=1 and cnt == eff-1, the channel SHALL invert clk_out[i] and clear cnt to 0; otherwise cnt SHALL increment by 1.
REQ-014 The clk_out[i] period SHALL be 2*eff clk_in cycles at 50% duty cycle; the first toggle SHALL occur eff cycles after the channel starts counting.
REQ-015 load[i]=1 SHALL write half_period[i] into shd and set a per-channel pending flag.
REQ-016 On a terminal cycle with the pending flag set, act SHALL take shd and the pending flag SHALL clear; act SHALL never change mid half-period.
REQ-017 If load[i] and the terminal condition coincide, the new half_period[i] value SHALL become act in that cycle (bypass) and the pending flag SHALL stay clear.
REQ-018 The counter compare SHALL use the full CNT_W width with no overflow path; cnt SHALL never exceed eff-1.
REQ-019 en[i]=0 SHALL clear cnt and clk_out[i] to 0 on the next edge; load SHALL still be accepted while disabled.
REQ-020 On the en[i] rising edge, any pending shd SHALL be applied to act, and counting SHALL start from cnt=0 with clk_out[i]=0.
REQ-021 sync=1 SHALL, on the next edge, clear cnt and clk_out in every channel and apply pending shadows; after sync, channels with equal eff SHALL toggle in the same cycle.
REQ-022 sync SHALL take priority over the terminal condition; a load coincident with sync SHALL be captured and applied.
REQ-023 Channels SHALL be fully independent apart from the shared sync input.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear in every channel: cnt=0, clk_out=0, tick=0, pending=0, act=1 and shd=1.
REQ-025 Reset asserted mid-period SHALL drive clk_out low immediately, without waiting for a clock edge.
REQ-026 After reset release, channels with en=1 SHALL produce divide-by-2 (act=1) until a load is applied.

Configuration
REQ-027 With macro CLK_DIV_TICK_EN defined, tick[i] SHALL be a registered pulse that is high for exactly the cycle in which clk_out[i] changes value, including the falling toggle caused by en deassertion.
REQ-028 Without CLK_DIV_TICK_EN, tick SHALL be tied to all zeros and no tick registers SHALL be synthesised; all other behaviour is unchanged.

Verification
REQ-029 Reset release, en=2'b11, no load -> both clk_out toggle every cycle (period 2).
REQ-030 load ch0 with 5 while running at act=1 -> the current half period completes, then ch0 shows a period of 10 with high=5, low=5 and no short pulse.
REQ-031 load ch1 with 0 -> ch1 runs at period 2 (eff=1); load with 3 coincident with a terminal -> the very next half period is 3 cycles.
REQ-032 ch0=4, ch1=4 started 2 cycles apart, then pulse sync -> both clk_out rise in the same cycle, 4 cycles after sync.
REQ-033 rst_n pulled low mid-high-phase -> clk_out=0 asynchronously; after release, divide-by-2 is restored and the prior load values are discarded.
REQ-034 With CLK_DIV_TICK_EN, ch0=3 -> tick[0] is high once every 3 cycles, aligned with each clk_out edge; without the macro, tick stays 0.
